// File: rtl/truth_table_extractor.sv
// Sweeps every input row of an attached combinational gate, assembles its truth
// table (row 0 in the MSB) and compares it against a captured golden code.
module truth_table_extractor #(
  parameter  int N_INPUTS      = 4,
  parameter  int SETTLE_CYCLES = 1,
  localparam int W             = 1 << N_INPUTS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [W-1:0]        expected,
  output logic [N_INPUTS-1:0] stim,
  input  logic                resp,
  output logic                busy,
  output logic                done,
  output logic [W-1:0]        truth_table,
  output logic                match,
  output logic [N_INPUTS-1:0] fail_idx
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam logic [1:0] ST_ROW      = (SETTLE_CYCLES > 0) ? ST_HOLD : ST_SAMPLE;

  logic [1:0]          state_reg, state_next;
  logic [N_INPUTS-1:0] stim_reg, stim_next;
  logic [3:0]          settle_reg, settle_next;
  logic [W-1:0]        tt_reg, tt_next;
  logic [W-1:0]        exp_reg, exp_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                match_reg, match_next;
  logic [N_INPUTS-1:0] fail_reg, fail_next;

  logic [W-1:0]        sampled_tt;
  logic [W-1:0]        diff;
  logic [W-1:0]        row_miss;
  logic [N_INPUTS-1:0] first_fail;

  // Row i lives at bit W-1-i, which for an N-bit row index is simply ~i.
  always_comb begin
    sampled_tt            = tt_reg;
    sampled_tt[~stim_reg] = resp;
    diff                  = sampled_tt ^ exp_reg;
  end

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_row_miss
      assign row_miss[gi] = diff[W-1-gi];
    end
  endgenerate

  // Descending scan so the lowest mismatching row is the one that sticks.
  always_comb begin
    first_fail = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (row_miss[i]) first_fail = N_INPUTS'(i);
    end
  end

  always_comb begin
    state_next  = state_reg;
    stim_next   = stim_reg;
    settle_next = settle_reg;
    tt_next     = tt_reg;
    exp_next    = exp_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    match_next  = match_reg;
    fail_next   = fail_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          exp_next    = expected;
          tt_next     = '0;
          stim_next   = '0;
          settle_next = SETTLE_LAST;
          busy_next   = 1'b1;
          match_next  = 1'b0;
          fail_next   = '0;
          state_next  = ST_ROW;
        end
      end
      ST_HOLD, ST_SAMPLE: begin
        if (abort) begin
          state_next = ST_IDLE;
          stim_next  = '0;
          busy_next  = 1'b0;
          match_next = 1'b0;
          fail_next  = '0;
        end else if (state_reg == ST_HOLD) begin
          if (settle_reg == 4'd0) state_next = ST_SAMPLE;
          else                    settle_next = settle_reg - 4'd1;
        end else begin
          tt_next = sampled_tt;
          if (&stim_reg) begin
            state_next = ST_FINISH;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            match_next = ~|diff;
            fail_next  = first_fail;
          end else begin
            stim_next   = stim_reg + 1'b1;
            settle_next = SETTLE_LAST;
            state_next  = ST_ROW;
          end
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      stim_reg   <= '0;
      settle_reg <= '0;
      tt_reg     <= '0;
      exp_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      match_reg  <= 1'b0;
      fail_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      stim_reg   <= stim_next;
      settle_reg <= settle_next;
      tt_reg     <= tt_next;
      exp_reg    <= exp_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      match_reg  <= match_next;
      fail_reg   <= fail_next;
    end
  end

  assign stim        = stim_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign truth_table = tt_reg;
  assign match       = match_reg;
  assign fail_idx    = fail_reg;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Two extractor instances: A (settle 1) wraps the gate a(b|~d)|b(c~^d),
// B (settle 0) wraps a gate tied to 1. Results are checked by per-instance scoreboards.
module tb_truth_table_extractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, abort_a, start_b, abort_b;
  logic [15:0] exp_a, exp_b, tt_a, tt_b;
  logic [3:0]  stim_a, stim_b, fail_a, fail_b;
  logic        resp_a, resp_b, busy_a, busy_b, done_a, done_b, match_a, match_b;

  // stim[3] is the first gate input a, stim[0] is d.
  assign resp_a = (stim_a[3] & (stim_a[2] | ~stim_a[0])) | (stim_a[2] & ~(stim_a[1] ^ stim_a[0]));
  assign resp_b = 1'b1;

  truth_table_extractor #(.N_INPUTS(4), .SETTLE_CYCLES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .expected(exp_a),
    .stim(stim_a), .resp(resp_a), .busy(busy_a), .done(done_a),
    .truth_table(tt_a), .match(match_a), .fail_idx(fail_a));

  truth_table_extractor #(.N_INPUTS(4), .SETTLE_CYCLES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .expected(exp_b),
    .stim(stim_b), .resp(resp_b), .busy(busy_b), .done(done_b),
    .truth_table(tt_b), .match(match_b), .fail_idx(fail_b));

  typedef struct {
    logic [15:0] tt;
    logic        match;
    logic [3:0]  fidx;
    int          done_cyc;
    string       name;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic score(input exp_t e, input logic [15:0] tt, input logic m, input logic [3:0] f);
    check({e.name, "_tt"}, 32'(tt), 32'(e.tt));
    check({e.name, "_match"}, 32'(m), 32'(e.match));
    check({e.name, "_fail_idx"}, 32'(f), 32'(e.fidx));
    check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
    $display("%s: tt=%h match=%b fail_idx=%0d cycle=%0d", e.name, tt, m, f, cyc);
  endtask

  always @(negedge clk) begin
    if (done_a) begin
      if (q_a.size() == 0) check("a_spurious_done", 32'(done_a), 32'd0);
      else score(q_a.pop_front(), tt_a, match_a, fail_a);
    end
  end

  always @(negedge clk) begin
    if (done_b) begin
      if (q_b.size() == 0) check("b_spurious_done", 32'(done_b), 32'd0);
      else score(q_b.pop_front(), tt_b, match_b, fail_b);
    end
  end

  // Call at a negedge; E0 is the next posedge and done shows after E0+W*(S+1).
  task automatic push(input bit b, input logic [15:0] ett, input logic em,
                      input logic [3:0] ef, input string nm);
    exp_t e;
    e.tt = ett; e.match = em; e.fidx = ef; e.name = nm;
    e.done_cyc = cyc + 1 + (b ? 16 : 32);
    if (b) q_b.push_back(e);
    else   q_a.push_back(e);
  endtask

  // Returns at the negedge following E0.
  task automatic issue(input bit b, input logic [15:0] ex);
    if (b) begin exp_b = ex; start_b = 1'b1; end
    else   begin exp_a = ex; start_a = 1'b1; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit b, input int budget, input string nm);
    int k = 0;
    while (((b ? done_b : done_a) !== 1'b1) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if ((b ? done_b : done_a) !== 1'b1) check({nm, "_timeout"}, 32'(b ? done_b : done_a), 32'd1);
  endtask

  initial begin
    int k;
    int cnt;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; exp_a = '0;
    start_b = 1'b0; abort_b = 1'b0; exp_b = '0;
    repeat (2) @(negedge clk);
    check("rst_stim", 32'(stim_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_tt", 32'(tt_a), 32'd0);
    check("rst_match", 32'(match_a), 32'd0);
    check("rst_fail_idx", 32'(fail_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: golden match; expected is scrambled after capture.
    push(1'b0, 16'h09AF, 1'b1, 4'd0, "t1");
    issue(1'b0, 16'h09AF);
    check("t1_busy", 32'(busy_a), 32'd1);
    exp_a = 16'h1234;
    wait_done(1'b0, 60, "t1");
    @(negedge clk);
    check("t1_done_pulse", 32'(done_a), 32'd0);
    check("t1_stim_hold", 32'(stim_a), 32'd15);
    check("t1_tt_hold", 32'(tt_a), 32'h09AF);

    // 2: last row differs.
    push(1'b0, 16'h09AF, 1'b0, 4'd15, "t2");
    issue(1'b0, 16'h09AE);
    wait_done(1'b0, 60, "t2");
    @(negedge clk);

    // 3: constant-one gate, no settle cycles; busy for exactly 16 cycles.
    push(1'b1, 16'hFFFF, 1'b1, 4'd0, "t3");
    issue(1'b1, 16'hFFFF);
    cnt = busy_b ? 1 : 0;
    k = 0;
    while (done_b !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
      if (busy_b) cnt++;
    end
    check("t3_busy_cycles", 32'(cnt), 32'd16);
    @(negedge clk);
    push(1'b1, 16'hFFFF, 1'b0, 4'd8, "t3b");
    issue(1'b1, 16'hFF7F);
    wait_done(1'b1, 40, "t3b");
    @(negedge clk);
    check("t3b_stim_hold", 32'(stim_b), 32'd15);

    // 4: abort while row 6 is held; rows 0..5 already sampled.
    issue(1'b0, 16'h09AF);
    repeat (12) @(negedge clk);
    check("t4_row", 32'(stim_a), 32'd6);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("t4_busy", 32'(busy_a), 32'd0);
    check("t4_stim", 32'(stim_a), 32'd0);
    check("t4_tt_partial", 32'(tt_a), 32'h0800);
    check("t4_match", 32'(match_a), 32'd0);
    check("t4_fail_idx", 32'(fail_a), 32'd0);
    repeat (40) @(negedge clk);
    check("t4_idle", 32'(busy_a), 32'd0);

    // 5: start held every cycle; start beats abort in IDLE.
    push(1'b0, 16'h09AF, 1'b1, 4'd0, "t5");
    exp_a = 16'h09AF;
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("t5_start_wins", 32'(busy_a), 32'd1);
    k = 0;
    while (done_a !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    start_a = 1'b0;
    check("t5_done_seen", 32'(done_a), 32'd1);
    repeat (5) @(negedge clk);
    check("t5_no_restart", 32'(busy_a), 32'd0);

    // 6: asynchronous reset at row 7, then a clean sweep.
    issue(1'b0, 16'h09AF);
    k = 0;
    while (stim_a !== 4'd7 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t6_row", 32'(stim_a), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_stim", 32'(stim_a), 32'd0);
    check("t6_rst_busy", 32'(busy_a), 32'd0);
    check("t6_rst_tt", 32'(tt_a), 32'd0);
    check("t6_rst_match", 32'(match_a), 32'd0);
    check("t6_rst_fail_idx", 32'(fail_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(1'b0, 16'h09AF, 1'b1, 4'd0, "t6");
    issue(1'b0, 16'h09AF);
    wait_done(1'b0, 60, "t6");
    repeat (3) @(negedge clk);

    check("a_queue_empty", 32'(q_a.size()), 32'd0);
    check("b_queue_empty", 32'(q_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
